key_sel_toggle: RTL and testbench

- Upstream control stage for the 2:1 multiplexer.
- Takes a raw, bouncy, active-low push-button, synchronizes and debounces it, and toggles a registered select line on each confirmed press.
- `sel` connects directly to the mux `sel` input, so each physical key press swaps the mux between `in1` and `in2`.
- Also emits a one-cycle press strobe for other consumers.

---
 rtl/key_sel_toggle.sv | 96 +++++++++
 tb/tb_key_sel_toggle.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/key_sel_toggle.sv
// Debounced push-button that toggles a registered 2:1 mux select.
// Ports: sys_clk, sys_rst (sync, active-high), key_in (raw, active-low),
//   sel (registered mux select), press_pulse (1-cycle press strobe).
module key_sel_toggle #(
  parameter int unsigned CNT_MAX  = 999_999,
  parameter logic        SEL_INIT = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic sel,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             key_d1;
  logic             key_s;

  // Two-flop synchronizer; idles high so reset looks like "released".
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_d1 <= 1'b1;
      key_s  <= 1'b1;
    end else begin
      key_d1 <= key_in;
      key_s  <= key_d1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sel         <= SEL_INIT;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!key_s) begin
            state <= PRESS_DB;
            cnt   <= '0;
          end
        end
        PRESS_DB: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= HELD;
            cnt         <= '0;
            sel         <= ~sel;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (key_s) begin
            state <= REL_DB;
            cnt   <= '0;
          end
        end
        REL_DB: begin
          // A low sample here is release bounce: back to HELD, no press.
          if (!key_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_sel_toggle.sv
// Bench for key_sel_toggle: run-length debounce model plus directed scenarios.
// Ports exercised: sys_clk, sys_rst, key_in, sel, press_pulse.
module tb_key_sel_toggle;

  localparam int CNT_MAX = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic sel;
  logic press_pulse;

  int nchk = 0;
  int nerr = 0;
  int npulse = 0;
  bit started = 1'b0;

  // Mux fed by sel, as downstream would see it: in1 = 0, in2 = 1.
  logic in1 = 1'b0;
  logic in2 = 1'b1;
  logic mux_out;
  assign mux_out = sel ? in2 : in1;

  key_sel_toggle #(
    .CNT_MAX (CNT_MAX),
    .SEL_INIT(1'b0)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .sel        (sel),
    .press_pulse(press_pulse)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a press is confirmed once the synchronized key has been seen
  // low for CNT_MAX+1 consecutive edges while armed; re-arming needs
  // CNT_MAX+1 consecutive high samples.
  logic m_d1 = 1'b1;
  logic m_s  = 1'b1;
  int   lowrun = 0;
  int   highrun = 0;
  bit   armed = 1'b1;
  logic m_sel = 1'b0;
  logic m_pulse = 1'b0;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_d1 = 1'b1;
      m_s = 1'b1;
      lowrun = 0;
      highrun = 0;
      armed = 1'b1;
      m_sel = 1'b0;
      m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (m_s == 1'b0) begin
        lowrun++;
        highrun = 0;
      end else begin
        highrun++;
        lowrun = 0;
      end
      if (armed && lowrun == CNT_MAX + 1) begin
        armed = 1'b0;
        m_sel = ~m_sel;
        m_pulse = 1'b1;
      end else if (!armed && highrun == CNT_MAX + 1) begin
        armed = 1'b1;
      end
      m_s = m_d1;
      m_d1 = key_in;
    end
  end

  always @(negedge sys_clk) begin
    if (started) begin
      check("model_sel", int'(sel), int'(m_sel));
      check("model_pulse", int'(press_pulse), int'(m_pulse));
      check("mux_out", int'(mux_out), int'(m_sel));
      if (press_pulse === 1'b1) npulse++;
    end
  end

  // Drive inputs for one cycle; returns at the next negedge, after which
  // the outputs reflect the edge that captured these inputs.
  task automatic cyc(input logic k, input logic r);
    key_in = k;
    sys_rst = r;
    @(negedge sys_clk);
  endtask

  task automatic run(input logic k, input int n);
    for (int i = 0; i < n; i++) cyc(k, 1'b0);
  endtask

  initial begin
    int p0;
    @(negedge sys_clk);
    // Reset for 5 cycles with key idle.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1);
      started = 1'b1;
      check("rst_sel", int'(sel), 0);
      check("rst_pulse", int'(press_pulse), 0);
    end
    run(1'b1, 5);
    check("post_rst_sel", int'(sel), 0);

    // Clean press: toggle lands on the 7th edge counting E1 as 1.
    p0 = npulse;
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, 1'b0);
      if (i == 6) check("clean_pre_sel", int'(sel), 0);
      if (i == 6) check("clean_pre_pulse", int'(press_pulse), 0);
      if (i == 7) check("clean_sel", int'(sel), 1);
      if (i == 7) check("clean_pulse", int'(press_pulse), 1);
      if (i == 8) check("clean_pulse_off", int'(press_pulse), 0);
    end
    run(1'b1, 20);
    check("clean_npulse", npulse - p0, 1);
    check("clean_rel_sel", int'(sel), 1);

    // Press bounce: never CNT_MAX+1 consecutive lows.
    p0 = npulse;
    run(1'b0, 3);
    run(1'b1, 1);
    run(1'b0, 3);
    run(1'b1, 20);
    check("bounce_npulse", npulse - p0, 0);
    check("bounce_sel", int'(sel), 1);

    // Confirmed press then release bounce: only one pulse.
    p0 = npulse;
    run(1'b0, 20);
    run(1'b1, 2);
    run(1'b0, 5);
    run(1'b1, 20);
    check("relb_npulse", npulse - p0, 1);
    check("relb_sel", int'(sel), 0);

    // Two full presses with a confirmed release in between.
    p0 = npulse;
    run(1'b0, 20);
    check("two_sel_a", int'(sel), 1);
    check("two_mux_a", int'(mux_out), 1);
    run(1'b1, 20);
    run(1'b0, 20);
    check("two_sel_b", int'(sel), 0);
    check("two_mux_b", int'(mux_out), 0);
    run(1'b1, 20);
    check("two_npulse", npulse - p0, 2);

    // Get sel to 1 so the mid-debounce reset is visible.
    run(1'b0, 20);
    run(1'b1, 20);
    check("pre_mid_sel", int'(sel), 1);

    // Reset at edge 5 after E1 with key held low, then re-confirm.
    p0 = npulse;
    run(1'b0, 4);
    cyc(1'b0, 1'b1);
    check("mid_rst_sel", int'(sel), 0);
    check("mid_rst_pulse", int'(press_pulse), 0);
    for (int j = 1; j <= 20; j++) begin
      cyc(1'b0, 1'b0);
      if (j == 6) check("mid_pre_sel", int'(sel), 0);
      if (j == 7) check("mid_sel", int'(sel), 1);
      if (j == 7) check("mid_pulse", int'(press_pulse), 1);
    end
    run(1'b1, 20);
    check("mid_npulse", npulse - p0, 1);
    check("mid_end_sel", int'(sel), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
